// File: rtl/memory_writeback_stage.sv
// MEM stage of the pipelined processor: word-addressed data memory plus the MEM/WB register and WB result mux.
// Stores and loads to a bad address fault; the store is dropped and the load data reads as zero.
module memory_writeback_stage #(
  parameter int W     = 32,
  parameter int DEPTH = 64
) (
  input  logic         clk,
  input  logic         reset_synchronous_n,
  input  logic         StallM,
  input  logic         FlushW,
  input  logic         PCSrcM,
  input  logic         RegWriteM,
  input  logic         MemWriteM,
  input  logic         MemtoRegM,
  input  logic [W-1:0] AluResultM,
  input  logic [W-1:0] WriteDataM,
  input  logic [3:0]   WA3M,
  output logic         AddrFaultM,
  output logic         PCSrcW,
  output logic         RegWriteW,
  output logic         MemtoRegW,
  output logic [W-1:0] ReadDataW,
  output logic [W-1:0] AluResultW,
  output logic [3:0]   WA3W,
  output logic [W-1:0] ResultW
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] index;
  logic          misaligned;
  logic          out_of_range;
  logic          addr_bad;
  logic          mem_we;
  logic [W-1:0]  read_data;

  assign index        = AluResultM[AW+1:2];
  assign misaligned   = |AluResultM[1:0];
  assign out_of_range = |AluResultM[W-1:AW+2];
  assign addr_bad     = misaligned | out_of_range;
  assign AddrFaultM   = (MemWriteM | MemtoRegM) & addr_bad;

  // Read data is forced to zero on a bad address so a faulting load never leaks another word.
  assign read_data = addr_bad ? '0 : mem[index];

  // Memory contents survive reset; only the write itself is suppressed while in reset.
  assign mem_we = reset_synchronous_n & MemWriteM & ~StallM & ~addr_bad;

  always_ff @(posedge clk) begin
    if (mem_we) mem[index] <= WriteDataM;
  end

  // Priority: reset, then flush (controls cleared, data still loads), then stall (hold), then load.
  always_ff @(posedge clk) begin
    if (!reset_synchronous_n) begin
      PCSrcW     <= 1'b0;
      RegWriteW  <= 1'b0;
      MemtoRegW  <= 1'b0;
      ReadDataW  <= '0;
      AluResultW <= '0;
      WA3W       <= '0;
    end else if (FlushW) begin
      PCSrcW     <= 1'b0;
      RegWriteW  <= 1'b0;
      MemtoRegW  <= 1'b0;
      ReadDataW  <= read_data;
      AluResultW <= AluResultM;
      WA3W       <= WA3M;
    end else if (!StallM) begin
      PCSrcW     <= PCSrcM;
      RegWriteW  <= RegWriteM;
      MemtoRegW  <= MemtoRegM;
      ReadDataW  <= read_data;
      AluResultW <= AluResultM;
      WA3W       <= WA3M;
    end
  end

  assign ResultW = MemtoRegW ? ReadDataW : AluResultW;

endmodule

// File: tb/tb_memory_writeback_stage.sv
// Bench for memory_writeback_stage: directed scenarios plus random traffic against a word-array
// reference model with an expected-result queue.
module tb_memory_writeback_stage;

  localparam int W     = 32;
  localparam int DEPTH = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         stall, flush, pcsrc, regw, memw, m2r;
  logic [W-1:0] alu, wd;
  logic [3:0]   wa3;
  logic         fault_m, pcsrc_w, regw_w, m2r_w;
  logic [W-1:0] rd_w, alu_w, result_w;
  logic [3:0]   wa3_w;

  memory_writeback_stage #(.W(W), .DEPTH(DEPTH)) dut (
    .clk                 (clk),
    .reset_synchronous_n (rst_n),
    .StallM              (stall),
    .FlushW              (flush),
    .PCSrcM              (pcsrc),
    .RegWriteM           (regw),
    .MemWriteM           (memw),
    .MemtoRegM           (m2r),
    .AluResultM          (alu),
    .WriteDataM          (wd),
    .WA3M                (wa3),
    .AddrFaultM          (fault_m),
    .PCSrcW              (pcsrc_w),
    .RegWriteW           (regw_w),
    .MemtoRegW           (m2r_w),
    .ReadDataW           (rd_w),
    .AluResultW          (alu_w),
    .WA3W                (wa3_w),
    .ResultW             (result_w)
  );

  // ---------------- reference model ----------------
  logic [W-1:0] m_mem [DEPTH];
  logic         e_pcsrc, e_regw, e_m2r;
  logic [W-1:0] e_rd, e_alu;
  logic [3:0]   e_wa3;
  logic [W-1:0] exp_q [$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set(input logic r, input logic s, input logic f, input logic p, input logic rw,
                     input logic mw, input logic mr, input logic [W-1:0] a, input logic [W-1:0] d,
                     input logic [3:0] w);
    rst_n = r; stall = s; flush = f; pcsrc = p; regw = rw;
    memw = mw; m2r = mr; alu = a; wd = d; wa3 = w;
  endtask

  // One clock: check the combinational fault, advance the model, clock, then check every W output.
  task automatic step(input string tag);
    bit           bad;
    int           idx;
    logic [W-1:0] rdata;
    #1;
    bad   = (alu % 4 != 0) || (alu >= DEPTH * 4);
    idx   = bad ? 0 : int'(alu / 4);
    rdata = bad ? '0 : m_mem[idx];
    check({tag, "_fault"}, {31'd0, fault_m}, {31'd0, (memw || m2r) && bad});
    if (!rst_n) begin
      e_pcsrc = 0; e_regw = 0; e_m2r = 0; e_rd = 0; e_alu = 0; e_wa3 = 0;
    end else begin
      if (memw && !stall && !bad) m_mem[idx] = wd;
      if (flush) begin
        e_pcsrc = 0; e_regw = 0; e_m2r = 0; e_rd = rdata; e_alu = alu; e_wa3 = wa3;
      end else if (!stall) begin
        e_pcsrc = pcsrc; e_regw = regw; e_m2r = m2r; e_rd = rdata; e_alu = alu; e_wa3 = wa3;
      end
    end
    exp_q.push_back(e_m2r ? e_rd : e_alu);
    @(posedge clk);
    #1;
    check({tag, "_pcsrc_w"},  {31'd0, pcsrc_w}, {31'd0, e_pcsrc});
    check({tag, "_regw_w"},   {31'd0, regw_w},  {31'd0, e_regw});
    check({tag, "_m2r_w"},    {31'd0, m2r_w},   {31'd0, e_m2r});
    check({tag, "_rd_w"},     rd_w,  e_rd);
    check({tag, "_alu_w"},    alu_w, e_alu);
    check({tag, "_wa3_w"},    {28'd0, wa3_w}, {28'd0, e_wa3});
    check({tag, "_result_w"}, result_w, exp_q.pop_front());
  endtask

  // ---------------- stimulus ----------------
  initial begin
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("rst0");
    step("rst1");

    // Give every word a known value so loads are predictable.
    for (int i = 0; i < DEPTH; i++) begin
      set(1, 0, 0, 0, 0, 1, 0, 32'(i * 4), 32'(i) * 32'h0101_0103 + 32'h77, 4'(i));
      step("init");
    end

    // Reset with all inputs asserted, then a reset cycle that would otherwise store to word 1.
    set(0, 1, 1, 1, 1, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hF);
    step("rst_ones");
    set(0, 0, 0, 1, 1, 1, 1, 32'h4, 32'hFFFF_FFFF, 4'hF);
    step("rst_store");
    check("rst_result_zero", result_w, 32'h0);
    set(1, 0, 0, 0, 1, 0, 1, 32'h4, 0, 4'd1);
    step("rst_mem1_kept");
    check("rst_mem1_value", rd_w, 32'h0101_0103 + 32'h77);

    // Store then load to the same address on consecutive cycles.
    set(1, 0, 0, 0, 0, 1, 0, 32'h8, 32'hDEAD_BEEF, 0);
    step("st");
    set(1, 0, 0, 0, 1, 0, 1, 32'h8, 0, 4'd5);
    step("ld");
    check("st_ld_result", result_w, 32'hDEAD_BEEF);
    check("st_ld_wa3", {28'd0, wa3_w}, 32'd5);

    // Faulting stores, then faulting loads.
    set(1, 0, 0, 0, 0, 1, 0, 32'h6, 32'h1111_2222, 0);
    step("flt_mis");
    set(1, 0, 0, 0, 0, 1, 0, 32'h100, 32'h3333_4444, 0);
    step("flt_oor");
    set(1, 0, 0, 0, 1, 0, 1, 32'h6, 0, 4'd2);
    step("flt_ld_mis");
    check("flt_ld_mis_zero", rd_w, 32'h0);
    set(1, 0, 0, 0, 1, 0, 1, 32'h100, 0, 4'd3);
    step("flt_ld_oor");
    check("flt_ld_oor_zero", rd_w, 32'h0);
    set(1, 0, 0, 0, 1, 0, 1, 32'h4, 0, 4'd3);
    step("flt_word1_intact");

    // Stall holds W registers and blocks the store; it commits once stall drops.
    for (int i = 0; i < 3; i++) begin
      set(1, 1, 0, 1, 1, 1, 0, 32'h4, 32'h55, 4'd9);
      step("stall");
    end
    set(1, 0, 0, 0, 1, 0, 1, 32'h4, 0, 4'd1);
    step("stall_not_written");
    set(1, 0, 0, 0, 0, 1, 0, 32'h4, 32'h55, 0);
    step("stall_release_st");
    set(1, 0, 0, 0, 1, 0, 1, 32'h4, 0, 4'd1);
    step("stall_ld");
    check("stall_ld_value", rd_w, 32'h55);

    // Flush beats stall.
    set(1, 1, 1, 1, 1, 0, 0, 32'h1234, 0, 4'd7);
    step("flush_stall");
    check("flush_regw_clear", {31'd0, regw_w}, 32'd0);
    check("flush_alu_loaded", alu_w, 32'h1234);

    // ALU passthrough.
    set(1, 0, 0, 1, 1, 0, 0, 32'hA5A5_A5A5, 0, 4'd15);
    step("pass");
    check("pass_result", result_w, 32'hA5A5_A5A5);
    check("pass_pcsrc", {31'd0, pcsrc_w}, 32'd1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] a;
      a = ($urandom_range(0, 9) < 8) ? 32'($urandom_range(0, DEPTH - 1) * 4) : $urandom;
      set(logic'($urandom_range(0, 39) != 0), logic'($urandom_range(0, 4) == 0),
          logic'($urandom_range(0, 7) == 0), logic'($urandom_range(0, 1)),
          logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
          logic'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
      step("rnd");
    end

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
